// File: rtl/readout_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : readout_pkg
//  Description : Shared types and constants for the buffer readout block and
//                the 7-segment decoder. The FSM state enum, buffer geometry,
//                the dash glyph and the hex glyph table live here.
//  Revision    : 1.0  initial release
// ============================================================================
package readout_pkg;

  localparam int DEPTH = 16;  // buffer entries
  localparam int AW    = 4;   // buffer address width
  localparam int DW    = 8;   // buffer data width (two hex digits)

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    SHOW  = 2'd3
  } readout_state_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_7seg
//  Description : Combinational hex nibble to active-low 7-segment decoder.
//  Ports       : i_hex  [3:0]  nibble to display
//                o_seg  [6:0]  segments {g,f,e,d,c,b,a}, active-low
//  Revision    : 1.0  initial release
// ============================================================================
module hex_to_7seg
  import readout_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_HEX[i_hex];

endmodule
`default_nettype wire

// File: rtl/buffer_readout.sv
`default_nettype none
// ============================================================================
//  Module      : buffer_readout
//  Description : Reads the byte-entry buffer back one entry per "next" press
//                and shows index (disp3:disp2) and data (disp1:disp0) in hex.
//  Ports       : clk      system clock
//                reset    asynchronous active-high reset
//                nnext    "next" button, active-low, asynchronous
//                count    valid entries in the buffer (0..DEPTH, clamped)
//                rd_en    one-cycle buffer read strobe
//                rd_addr  buffer read address
//                rd_data  buffer read data, valid the cycle after rd_en
//                disp3..0 active-low 7-segment digits
//  Revision    : 1.0  initial release
// ============================================================================
module buffer_readout
  import readout_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          nnext,
  input  logic [AW:0]   count,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [6:0]    disp3,
  output logic [6:0]    disp2,
  output logic [6:0]    disp1,
  output logic [6:0]    disp0
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  // Button synchroniser and falling-edge detector. Reset to 1 (released) so
  // that leaving reset never looks like a press.
  logic r_sync1, r_sync2, r_sync3, r_next_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_sync3      <= 1'b1;
      r_next_pulse <= 1'b0;
    end else begin
      r_sync1      <= nnext;
      r_sync2      <= r_sync1;
      r_sync3      <= r_sync2;
      r_next_pulse <= r_sync3 & ~r_sync2;
    end
  end

  logic [AW:0] w_count_c;
  assign w_count_c = (count > C_DEPTH) ? C_DEPTH : count;

  readout_state_t r_state, w_state_nxt;
  logic [AW-1:0]  r_idx, w_idx_nxt;
  logic [AW-1:0]  r_shown_idx;
  logic [DW-1:0]  r_data;
  logic           r_valid;  // shown_idx/data_reg hold a real entry
  logic           w_rd_en;
  logic [AW:0]    w_idx_ext, w_idx_inc;

  assign w_idx_ext = {1'b0, r_idx};
  assign w_idx_inc = w_idx_ext + (AW+1)'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rd_en     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_count_c != '0) begin
          w_state_nxt = FETCH;
          w_idx_nxt   = '0;
        end
      end
      FETCH: begin
        w_rd_en     = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        w_state_nxt = SHOW;
      end
      SHOW: begin
        if (w_count_c == '0) begin
          w_state_nxt = EMPTY;
          w_idx_nxt   = '0;
        end else if (w_idx_ext >= w_count_c) begin
          // Buffer shrank under the shown entry: restart from entry 0.
          w_state_nxt = FETCH;
          w_idx_nxt   = '0;
        end else if (r_next_pulse) begin
          w_state_nxt = FETCH;
          w_idx_nxt   = (w_idx_inc == w_count_c) ? '0 : w_idx_inc[AW-1:0];
        end
      end
      default: begin
        w_state_nxt = EMPTY;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_idx       <= '0;
      r_shown_idx <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (r_state == WAIT) begin
        r_data      <= rd_data;
        r_shown_idx <= r_idx;
        r_valid     <= 1'b1;
      end else if (w_state_nxt == EMPTY) begin
        r_valid <= 1'b0;
      end
    end
  end

  // rd_en is decoded from the state register so an asynchronous reset
  // removes it immediately.
  assign rd_en   = w_rd_en;
  assign rd_addr = r_idx;

  // Display: index zero-extended to two digits, data as two digits.
  logic [7:0] w_idx8;
  logic [3:0] w_nib [4];
  logic [6:0] w_seg [4];

  assign w_idx8   = {{(8-AW){1'b0}}, r_shown_idx};
  assign w_nib[3] = w_idx8[7:4];
  assign w_nib[2] = w_idx8[3:0];
  assign w_nib[1] = r_data[7:4];
  assign w_nib[0] = r_data[3:0];

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    hex_to_7seg u_dec (
      .i_hex (w_nib[gi]),
      .o_seg (w_seg[gi])
    );
  end

  assign disp3 = r_valid ? w_seg[3] : SEG_DASH;
  assign disp2 = r_valid ? w_seg[2] : SEG_DASH;
  assign disp1 = r_valid ? w_seg[1] : SEG_DASH;
  assign disp0 = r_valid ? w_seg[0] : SEG_DASH;

endmodule
`default_nettype wire
